// File: rtl/nn_pkg.sv
// Shared definitions for the ECG network classification datapath:
// activation width/type, the argmax scan FSM state encoding and the
// ReLU clamp applied to every activation before it is compared.
package nn_pkg;

    // Width of one node activation, matching the dense-layer node outputs.
    localparam int DW = 16;

    // One node activation as produced by the ReLU stage.
    typedef logic [DW-1:0] act_t;

    // Argmax scan controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Defensive ReLU: a set sign bit is treated as zero, so the remaining
    // DW-1 magnitude bits can be compared as an unsigned number.
    function automatic act_t clamp_relu(input act_t x);
        act_t r;
        if (x[DW-1] == 1'b1) begin
            r = {DW{1'b0}};
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_argmax.sv
// Sequential argmax over one frame of ReLU'd node outputs.
// A frame is captured in parallel into a register array, then scanned one
// element per cycle with a single comparator. The winning index/value is
// presented on a registered valid/ready output port. Ties keep the lowest
// index because only a strictly greater element replaces the current best.
module output_argmax
    import nn_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN*DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        class_idx,
    output logic [DW-1:0]        class_val,
    output logic                 busy
);

    // FSM state and scan position
    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    // Running best candidate
    act_t          best_val_q, best_val_d;
    logic [IW-1:0] best_idx_q, best_idx_d;

    // Captured frame
    act_t          buf_q [NUM_IN];
    act_t          buf_d [NUM_IN];

    // Registered outputs
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] class_idx_q, class_idx_d;
    act_t          class_val_q, class_val_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    // Handshake and scan helpers
    logic          accept_s;
    logic          last_s;
    act_t          scan_elem_s;

    assign accept_s = in_valid & in_ready_q & (state_q == IDLE);
    assign last_s   = (cnt_q == IW'(NUM_IN - 1));

    generate
        if (NUM_IN > 1) begin : g_multi
            // Select the clamped element currently under the comparator.
            always_comb begin
                scan_elem_s = clamp_relu(buf_q[cnt_q]);
            end
        end else begin : g_single
            // Single-element frames never scan; tie the comparator input off.
            always_comb begin
                scan_elem_s = clamp_relu(buf_q[0]);
            end
        end
    endgenerate

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {IW{1'b0}};
            best_val_q  <= {DW{1'b0}};
            best_idx_q  <= {IW{1'b0}};
            out_valid_q <= 1'b0;
            class_idx_q <= {IW{1'b0}};
            class_val_q <= {DW{1'b0}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                buf_q[k] <= {DW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            for (int k = 0; k < NUM_IN; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    // Next-state logic: capture, scan NUM_IN-1 further elements, then hold
    // the result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (NUM_IN == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: frame capture in IDLE, compare/update of the best candidate
    // in SCAN. The buffer is only written on an accepted frame.
    always_comb begin
        cnt_d      = cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        for (int k = 0; k < NUM_IN; k++) begin
            buf_d[k] = buf_q[k];
        end
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        buf_d[k] = in_data[k*DW +: DW];
                    end
                    best_val_d = clamp_relu(in_data[DW-1:0]);
                    best_idx_d = {IW{1'b0}};
                    if (NUM_IN == 1) begin
                        cnt_d = {IW{1'b0}};
                    end else begin
                        cnt_d = IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SCAN: begin
                if (scan_elem_s > best_val_q) begin
                    best_val_d = scan_elem_s;
                    best_idx_d = cnt_q;
                end else begin
                    best_val_d = best_val_q;
                    best_idx_d = best_idx_q;
                end
                if (last_s) begin
                    cnt_d = {IW{1'b0}};
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            DONE: begin
                cnt_d = {IW{1'b0}};
            end
            default: begin
                cnt_d = {IW{1'b0}};
            end
        endcase
    end

    // Output register inputs, all derived from the next state so that every
    // port is a flop and no in_*/out_ready path reaches an output in-cycle.
    always_comb begin
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        if ((state_d == DONE) && (state_q != DONE)) begin
            class_idx_d = best_idx_d;
            class_val_d = best_val_d;
        end else begin
            class_idx_d = class_idx_q;
            class_val_d = class_val_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign class_val = class_val_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_output_argmax.sv
// Directed scoreboard bench for output_argmax: an 8-input and a 1-input
// instance share clock and reset. Stimulus pushes hand-computed results
// (index, value, cycle of first out_valid) into queues; monitors compare
// every cycle out_valid is high and pop on the handshake.
module tb_output_argmax;

    logic         clk;
    logic         reset;

    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [127:0] in_data8;
    logic [2:0]   class_idx8;
    logic [15:0]  class_val8;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [15:0]  in_data1;
    logic [0:0]   class_idx1;
    logic [15:0]  class_val1;

    int cyc    = 0;
    int n_vec  = 0;
    int n_bad  = 0;

    typedef struct {
        int idx;
        int val;
        int t;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    logic ov8_prev = 1'b0;
    logic ov1_prev = 1'b0;

    output_argmax #(.NUM_IN(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .class_idx(class_idx8), .class_val(class_val8), .busy(busy8)
    );

    output_argmax #(.NUM_IN(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .class_idx(class_idx1), .class_val(class_val1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp_v, exp_v, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [127:0] pack8(
        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
        input logic [15:0] e4, input logic [15:0] e5, input logic [15:0] e6, input logic [15:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Called right after a negedge; returns right after the negedge that
    // follows the acceptance edge.
    task automatic send8(input logic [127:0] d, input bit push, input int idx, input int val);
        bit ok;
        ok = 1'b0;
        in_data8  = d;
        in_valid8 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            note_fail("send8_in_ready");
            in_valid8 = 1'b0;
            return;
        end
        if (push) q8.push_back('{idx, val, cyc + 8});
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_data8  = {4{32'hdead_beef}};
        @(negedge clk);
    endtask

    task automatic send1(input logic [15:0] d, input int val);
        bit ok;
        ok = 1'b0;
        in_data1  = d;
        in_valid1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            note_fail("send1_in_ready");
            in_valid1 = 1'b0;
            return;
        end
        q1.push_back('{0, val, cyc + 1});
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_data1  = 16'hbeef;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if ((q8.size() == 0) && (q1.size() == 0)) break;
            @(negedge clk);
        end
        chk("drain_q8", q8.size(), 0);
        chk("drain_q1", q1.size(), 0);
        @(negedge clk);
    endtask

    // Monitor for the 8-input instance.
    always @(negedge clk) begin
        if (out_valid8) begin
            if (q8.size() == 0) begin
                note_fail("o8_unexpected_out_valid");
            end else begin
                if (!ov8_prev) chk("o8_latency", cyc, q8[0].t);
                chk("o8_class_idx", int'(class_idx8), q8[0].idx);
                chk("o8_class_val", int'(class_val8), q8[0].val);
                chk("o8_busy", int'(busy8), 1);
                if (out_ready8) void'(q8.pop_front());
            end
        end
        ov8_prev <= out_valid8;
    end

    // Monitor for the 1-input instance.
    always @(negedge clk) begin
        if (out_valid1) begin
            if (q1.size() == 0) begin
                note_fail("o1_unexpected_out_valid");
            end else begin
                if (!ov1_prev) chk("o1_latency", cyc, q1[0].t);
                chk("o1_class_idx", int'(class_idx1), q1[0].idx);
                chk("o1_class_val", int'(class_val1), q1[0].val);
                if (out_ready1) void'(q1.pop_front());
            end
        end
        ov1_prev <= out_valid1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset      = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = 128'd0;
        out_ready8 = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = 16'd0;
        out_ready1 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready8", int'(in_ready8), 0);
        chk("rst_out_valid8", int'(out_valid8), 0);
        chk("rst_in_ready1", int'(in_ready1), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_in_ready8", int'(in_ready8), 1);
        chk("post_rst_busy8", int'(busy8), 0);
        chk("post_rst_idx8", int'(class_idx8), 0);
        chk("post_rst_val8", int'(class_val8), 0);
        chk("post_rst_out_valid8", int'(out_valid8), 0);
        chk("post_rst_in_ready1", int'(in_ready1), 1);

        // Basic frame, tie, all-zero, negative clamp
        send8(pack8(16'd10, 16'd200, 16'd35, 16'd0, 16'd199, 16'd7, 16'd1, 16'd3), 1'b1, 1, 200);
        chk("busy_in_scan", int'(busy8), 1);
        chk("in_ready_in_scan", int'(in_ready8), 0);
        drain();
        send8(pack8(16'd5, 16'd90, 16'd90, 16'd90, 16'd0, 16'd0, 16'd0, 16'd0), 1'b1, 1, 90);
        drain();
        send8(128'd0, 1'b1, 0, 0);
        drain();
        send8(pack8(16'h8005, 16'h0004, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), 1'b1, 1, 4);
        drain();

        // Backpressure, ignored in_valid while DONE, back-to-back release
        out_ready8 = 1'b0;
        send8(pack8(16'd100, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd300), 1'b1, 7, 300);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid8) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) note_fail("bp_out_valid_wait");
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", int'(in_ready8), 0);
            chk("bp_out_valid", int'(out_valid8), 1);
            if (k == 1) begin
                in_data8  = pack8(16'd9, 16'd1, 16'd2, 16'd50, 16'd3, 16'd50, 16'd0, 16'd0);
                in_valid8 = 1'b1;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready8), 1);
        send8(pack8(16'd9, 16'd1, 16'd2, 16'd50, 16'd3, 16'd50, 16'd0, 16'd0), 1'b1, 3, 50);
        drain();

        // Reset in the middle of a scan aborts the frame
        send8(pack8(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(out_valid8), 0);
        chk("abort_class_idx", int'(class_idx8), 0);
        chk("abort_class_val", int'(class_val8), 0);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_in_ready", int'(in_ready8), 0);
        repeat (12) @(negedge clk);
        chk("abort_idle_in_ready", int'(in_ready8), 1);

        // Frame after reset: clamped 0xFFFF, max magnitude tie
        send8(pack8(16'h0001, 16'hffff, 16'h7fff, 16'h7fff, 16'd0, 16'd0, 16'd0, 16'd0), 1'b1, 2, 32767);
        drain();

        // Single-input instance
        send1(16'h1234, 32'h1234);
        drain();
        send1(16'h9234, 0);
        drain();
        send1(16'h7fff, 32'h7fff);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
